// File: rtl/ivector_driver.sv
// Traffic source and in-order checker for an IVector-style echo path.
// Issues say(meth, v) requests, queues what it sent, and scores the returning heard() stream.
//   state | meaning
//   IDLE  | waiting for a start, scoreboard empty
//   SEND  | issuing requests while counting responses
//   DRAIN | all requests issued, waiting for the remaining responses
//   DONE  | run complete, counters hold until the next start
module ivector_driver #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             start__ENA,
   input  logic [CNT_W-1:0] start_count,
   output logic             start__RDY,
   output logic             say__ENA,
   output logic [5:0]       say_meth,
   output logic [3:0]       say_v,
   input  logic             say__RDY,
   input  logic             heard__ENA,
   input  logic [5:0]       heard_meth,
   input  logic [3:0]       heard_v,
   output logic             heard__RDY,
   output logic             done,
   output logic [CNT_W-1:0] sent_count,
   output logic [CNT_W-1:0] recv_count,
   output logic [CNT_W-1:0] err_count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DRAIN, ST_DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] total_q, total_d;
   logic [CNT_W-1:0] sent_q, sent_d;
   logic [CNT_W-1:0] recv_q, recv_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [PW-1:0]    wr_q, wr_d;
   logic [PW-1:0]    rd_q, rd_d;
   logic [PW:0]      occ_q, occ_d;
   logic [9:0]       sb_mem [DEPTH];

   logic [5:0] n6;
   logic       active, push, pop, mismatch, err_inc, start_fire;

   assign n6       = 6'(sent_q);
   assign say_meth = n6 ^ 6'h15;
   assign say_v    = n6[3:0] + 4'd3;

   assign start__RDY = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign done       = (state_q == ST_DONE);
   assign heard__RDY = (occ_q != '0);
   assign sent_count = sent_q;
   assign recv_count = recv_q;
   assign err_count  = err_q;

   assign active     = (state_q == ST_SEND) || (state_q == ST_DRAIN);
   assign say__ENA   = (state_q == ST_SEND) && say__RDY && (occ_q < FULL) && (sent_q < total_q);
   assign push       = say__ENA;
   assign pop        = active && heard__ENA && heard__RDY;
   assign mismatch   = ({heard_meth, heard_v} != sb_mem[rd_q]);
   // an indication against an empty scoreboard is scored as an error, never popped
   assign err_inc    = active && heard__ENA && (!heard__RDY || mismatch);
   assign start_fire = start__ENA && start__RDY;

   always_comb begin
      state_d = state_q;
      total_d = total_q;
      sent_d  = sent_q;
      recv_d  = recv_q;
      err_d   = err_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      occ_d   = occ_q;
      if (start_fire) begin
         total_d = start_count;
         sent_d  = '0;
         recv_d  = '0;
         err_d   = '0;
         wr_d    = '0;
         rd_d    = '0;
         occ_d   = '0;
         state_d = (start_count == '0) ? ST_DONE : ST_SEND;
      end else begin
         if (push) begin
            wr_d   = wr_q + 1'b1;
            sent_d = sent_q + 1'b1;
         end
         if (pop) begin
            rd_d   = rd_q + 1'b1;
            recv_d = recv_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
         endcase
         if (err_inc && (err_q != '1))
            err_d = err_q + 1'b1;
         case (state_q)
            ST_SEND:  if (push && (sent_d == total_q)) state_d = ST_DRAIN;
            ST_DRAIN: if (recv_d == total_q) state_d = ST_DONE;
            default:  state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= ST_IDLE;
         total_q <= '0;
         sent_q  <= '0;
         recv_q  <= '0;
         err_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         occ_q   <= '0;
      end else begin
         state_q <= state_d;
         total_q <= total_d;
         sent_q  <= sent_d;
         recv_q  <= recv_d;
         err_q   <= err_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         occ_q   <= occ_d;
      end
   end

   // storage needs no reset: occupancy gates every read
   always_ff @(posedge CLK) begin
      if (push)
         sb_mem[wr_q] <= {say_meth, say_v};
   end

endmodule

// File: tb/tb_ivector_driver.sv
// Directed bench for ivector_driver: a 2-cycle echo model answers each request,
// with optional withholding and single-response corruption.
module tb_ivector_driver;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;

   logic             CLK = 1'b0;
   logic             nRST, start__ENA, say__RDY, heard__ENA;
   logic [CNT_W-1:0] start_count;
   logic [5:0]       heard_meth;
   logic [3:0]       heard_v;
   logic             start__RDY, say__ENA, heard__RDY, done;
   logic [5:0]       say_meth;
   logic [3:0]       say_v;
   logic [CNT_W-1:0] sent_count, recv_count, err_count;

   ivector_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .nRST(nRST),
      .start__ENA(start__ENA), .start_count(start_count), .start__RDY(start__RDY),
      .say__ENA(say__ENA), .say_meth(say_meth), .say_v(say_v), .say__RDY(say__RDY),
      .heard__ENA(heard__ENA), .heard_meth(heard_meth), .heard_v(heard_v),
      .heard__RDY(heard__RDY), .done(done),
      .sent_count(sent_count), .recv_count(recv_count), .err_count(err_count)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc = 0;
   int n_say = 0;
   int n_heard = 0;
   logic [5:0] obs_meth [128];
   logic [3:0] obs_v    [128];
   int         obs_cyc  [128];
   logic [9:0] eq [$];
   int         edue [$];

   task automatic step();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic clear_echo();
      eq.delete();
      edue.delete();
      n_say = 0;
      n_heard = 0;
   endtask

   task automatic do_start(input int cnt);
      clear_echo();
      start_count = CNT_W'(cnt);
      start__ENA = 1'b1;
      step();
      start__ENA = 1'b0;
   endtask

   // one echo cycle: answer the oldest due request, record any request issued
   task automatic tick_echo(input bit allow, input int corrupt);
      heard__ENA = 1'b0;
      if (allow && eq.size() > 0 && edue[0] <= cyc) begin
         heard__ENA = 1'b1;
         {heard_meth, heard_v} = eq[0];
         if (n_heard == corrupt) heard_v = heard_v ^ 4'd1;
         eq.pop_front();
         edue.pop_front();
         n_heard++;
      end
      #1;
      if (say__ENA) begin
         if (n_say < 128) begin
            obs_meth[n_say] = say_meth;
            obs_v[n_say]    = say_v;
            obs_cyc[n_say]  = cyc;
         end
         eq.push_back({say_meth, say_v});
         edue.push_back(cyc + 2);
         n_say++;
      end
      step();
      heard__ENA = 1'b0;
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      say__RDY = 1'b1;
      step();
      step();
      n_cmp++; if (start__RDY !== 1'b1) begin n_mis++; $display("FAIL reset_start_rdy: got %b want 1", start__RDY); end
      n_cmp++; if ({done, say__ENA, heard__RDY} !== 3'b000) begin n_mis++; $display("FAIL reset_flags: got %b want 000", {done, say__ENA, heard__RDY}); end
      n_cmp++; if ({say_meth, say_v} !== {6'h15, 4'h3}) begin n_mis++; $display("FAIL reset_payload: got %h/%h want 15/3", say_meth, say_v); end
      n_cmp++; if ({sent_count, recv_count, err_count} !== '0) begin n_mis++; $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", sent_count, recv_count, err_count); end
      nRST = 1'b1;
      step();
   endtask

   task automatic test_basic();
      logic [5:0] em [5];
      em[0] = 6'h15; em[1] = 6'h14; em[2] = 6'h17; em[3] = 6'h16; em[4] = 6'h11;
      do_start(5);
      tick_echo(1'b1, -1);
      n_cmp++; if (n_say !== 1) begin n_mis++; $display("FAIL basic_start_latency: got %0d says want 1", n_say); end
      for (int i = 0; i < 50 && !done; i++) tick_echo(1'b1, -1);
      n_cmp++; if (done !== 1'b1) begin n_mis++; $display("FAIL basic_done: got %b want 1", done); end
      n_cmp++; if (n_say !== 5) begin n_mis++; $display("FAIL basic_say_count: got %0d want 5", n_say); end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({obs_meth[i], obs_v[i]} !== {em[i], 4'(i + 3)}) begin
            n_mis++; $display("FAIL basic_payload[%0d]: got %h/%h want %h/%h", i, obs_meth[i], obs_v[i], em[i], 4'(i + 3));
         end
      end
      n_cmp++; if (obs_cyc[4] - obs_cyc[0] !== 4) begin n_mis++; $display("FAIL basic_back_to_back: got span %0d want 4", obs_cyc[4] - obs_cyc[0]); end
      n_cmp++; if ({sent_count, recv_count, err_count} !== {8'd5, 8'd5, 8'd0}) begin n_mis++; $display("FAIL basic_counts: got %0d/%0d/%0d want 5/5/0", sent_count, recv_count, err_count); end
      n_cmp++; if (start__RDY !== 1'b1) begin n_mis++; $display("FAIL basic_start_rdy: got %b want 1", start__RDY); end
   endtask

   task automatic test_backpressure();
      do_start(10);
      for (int i = 0; i < 8; i++) tick_echo(1'b0, -1);
      n_cmp++; if (n_say !== 4) begin n_mis++; $display("FAIL bp_says_held: got %0d want 4", n_say); end
      n_cmp++; if (say__ENA !== 1'b0) begin n_mis++; $display("FAIL bp_say_ena: got %b want 0", say__ENA); end
      n_cmp++; if ({sent_count, recv_count, heard__RDY} !== {8'd4, 8'd0, 1'b1}) begin n_mis++; $display("FAIL bp_occupancy: got sent %0d recv %0d rdy %b want 4/0/1", sent_count, recv_count, heard__RDY); end
      for (int i = 0; i < 80 && !done; i++) tick_echo(1'b1, -1);
      n_cmp++; if (done !== 1'b1) begin n_mis++; $display("FAIL bp_done: got %b want 1", done); end
      n_cmp++; if ({obs_meth[9], obs_v[9]} !== {6'h1C, 4'hC}) begin n_mis++; $display("FAIL bp_payload9: got %h/%h want 1c/c", obs_meth[9], obs_v[9]); end
      n_cmp++; if ({sent_count, recv_count, err_count} !== {8'd10, 8'd10, 8'd0}) begin n_mis++; $display("FAIL bp_counts: got %0d/%0d/%0d want 10/10/0", sent_count, recv_count, err_count); end
   endtask

   task automatic test_corrupt();
      do_start(6);
      for (int i = 0; i < 60 && !done; i++) tick_echo(1'b1, 2);
      n_cmp++; if (done !== 1'b1) begin n_mis++; $display("FAIL corrupt_done: got %b want 1", done); end
      n_cmp++; if ({recv_count, err_count} !== {8'd6, 8'd1}) begin n_mis++; $display("FAIL corrupt_counts: got recv %0d err %0d want 6/1", recv_count, err_count); end
   endtask

   task automatic test_unexpected();
      say__RDY = 1'b0;
      do_start(3);
      heard__ENA = 1'b1;
      heard_meth = 6'h00;
      heard_v = 4'h0;
      step();
      heard__ENA = 1'b0;
      n_cmp++; if ({recv_count, err_count} !== {8'd0, 8'd1}) begin n_mis++; $display("FAIL unexp_counts: got recv %0d err %0d want 0/1", recv_count, err_count); end
      n_cmp++; if ({start__RDY, heard__RDY} !== 2'b00) begin n_mis++; $display("FAIL unexp_state: got rdy %b heard_rdy %b want 0/0", start__RDY, heard__RDY); end
      say__RDY = 1'b1;
      for (int i = 0; i < 40 && !done; i++) tick_echo(1'b1, -1);
      n_cmp++; if ({done, recv_count, err_count} !== {1'b1, 8'd3, 8'd1}) begin n_mis++; $display("FAIL unexp_final: got done %b recv %0d err %0d want 1/3/1", done, recv_count, err_count); end
      do_start(0);
      n_cmp++; if ({done, sent_count, err_count} !== {1'b1, 8'd0, 8'd0}) begin n_mis++; $display("FAIL zero_run: got done %b sent %0d err %0d want 1/0/0", done, sent_count, err_count); end
      n_cmp++; if (say__ENA !== 1'b0) begin n_mis++; $display("FAIL zero_say_ena: got %b want 0", say__ENA); end
   endtask

   task automatic test_wrap();
      int bad = 0;
      logic [5:0] m;
      logic [3:0] v;
      do_start(70);
      for (int i = 0; i < 300 && !done; i++) tick_echo(1'b1, -1);
      n_cmp++; if ({done, sent_count, err_count} !== {1'b1, 8'd70, 8'd0}) begin n_mis++; $display("FAIL wrap_final: got done %b sent %0d err %0d want 1/70/0", done, sent_count, err_count); end
      n_cmp++; if ({obs_v[12], obs_v[13]} !== {4'hF, 4'h0}) begin n_mis++; $display("FAIL wrap_v: got %h,%h want f,0", obs_v[12], obs_v[13]); end
      n_cmp++; if ({obs_meth[63], obs_meth[64]} !== {6'h2A, 6'h15}) begin n_mis++; $display("FAIL wrap_meth: got %h,%h want 2a,15", obs_meth[63], obs_meth[64]); end
      for (int i = 0; i < 70; i++) begin
         m = 6'(i) ^ 6'h15;
         v = 4'(i + 3);
         if ({obs_meth[i], obs_v[i]} !== {m, v}) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_mis++; $display("FAIL wrap_all_payload: got %0d bad entries want 0", bad); end
   endtask

   task automatic test_reset_midrun();
      do_start(6);
      for (int i = 0; i < 3; i++) tick_echo(1'b1, -1);
      n_cmp++; if ({sent_count, recv_count} !== {8'd3, 8'd1}) begin n_mis++; $display("FAIL midrun_pre: got sent %0d recv %0d want 3/1", sent_count, recv_count); end
      nRST = 1'b0;
      step();
      nRST = 1'b1;
      n_cmp++; if ({start__RDY, heard__RDY, done} !== 3'b100) begin n_mis++; $display("FAIL midrun_flags: got %b want 100", {start__RDY, heard__RDY, done}); end
      n_cmp++; if ({sent_count, recv_count, err_count} !== '0) begin n_mis++; $display("FAIL midrun_counts: got %0d/%0d/%0d want 0/0/0", sent_count, recv_count, err_count); end
      clear_echo();
      heard__ENA = 1'b1;
      step();
      heard__ENA = 1'b0;
      n_cmp++; if ({err_count, recv_count, say__ENA} !== {8'd0, 8'd0, 1'b0}) begin n_mis++; $display("FAIL midrun_idle_heard: got err %0d recv %0d say %b want 0/0/0", err_count, recv_count, say__ENA); end
   endtask

   initial begin
      nRST = 1'b0;
      start__ENA = 1'b0;
      start_count = '0;
      say__RDY = 1'b1;
      heard__ENA = 1'b0;
      heard_meth = '0;
      heard_v = '0;
      test_reset();
      test_basic();
      test_backpressure();
      test_corrupt();
      test_unexpected();
      test_wrap();
      test_reset_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
